shiftadd_multiplier: RTL
========================

Name: shiftadd_multiplier

Overview:
- Sequential shift-add multiply-accumulate, one multiplier bit per cycle: dout = multiplicand * multiplier + addend.
- It is the inverse companion of the shift-subtract divider. Feeding it a quotient, divisor and remainder rebuilds the dividend.
- Used as a standalone low-area multiplier and as the check path in divider self-test benches.

Parameters:
- WIDTH, 4: multiplier (divisor) width. Multiplicand and addend are 2*WIDTH bits; the result is 3*WIDTH bits.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- multiplicand  in  2*WIDTH  unsigned operand A (divider quotient)
- multiplier  in  WIDTH  unsigned operand B (divider divisor)
- addend  in  2*WIDTH  unsigned value added to the product (divider remainder)
- din_valid  in  1  input operands valid this cycle
- din_ready  out  1  block can accept operands; combinational, equals (state==IDLE)
- dout  out  3*WIDTH  result register; holds the last result until the next completion
- dout_valid  out  1  one-cycle pulse, dout is new this cycle

Behaviour:
- Reset (async, rst_n low): state=IDLE, dout=0, dout_valid=0, all internal registers = 0. An operation in flight is discarded and produces no dout_valid after reset release.
- Internal registers:
  - acc, 3*WIDTH bits.
  - mcand_sh, 3*WIDTH bits, multiplicand shifted left.
  - mplier_sh, WIDTH bits, multiplier shifted right.
  - cnt, enough bits to hold WIDTH.
- States:
  - IDLE: din_ready=1. On a clock edge with din_valid=1:
    - acc <= zero-extended addend
    - mcand_sh <= zero-extended multiplicand
    - mplier_sh <= multiplier
    - cnt <= 0
    - go to CALC
    - With din_valid=0, registers hold.
  - CALC: din_ready=0; din_valid is ignored and operands are not sampled. Each edge:
    - if mplier_sh[0]=1 then acc <= acc + mcand_sh
    - mcand_sh <= mcand_sh << 1
    - mplier_sh <= mplier_sh >> 1
    - cnt <= cnt + 1
  - Completion: on the edge where cnt==WIDTH-1 (the last iteration):
    - dout <= final accumulated value, including this iteration's add
    - dout_valid <= 1
    - state <= IDLE
- dout_valid is a registered pulse, cleared on the next edge unless another completion occurs.
- Latency: operands accepted at edge E; dout_valid is high in the cycle following edge E+WIDTH. Fixed latency, no early termination when the multiplier is 0.
- Throughput: one operation per WIDTH+1 cycles.
- din_ready is high again in the same cycle dout_valid is high, so back-to-back issue is allowed. A new acceptance in that cycle does not disturb dout or dout_valid.
- Width rule: the maximum result, (2^(2W)-1)(2^(W)-1)+(2^(2W)-1) = (2^(2W)-1)*2^W, fits in 3*WIDTH bits, so the add never overflows. All arithmetic is unsigned.
- Operands need not be held stable after acceptance.
- X on din_valid while in IDLE is illegal. No other input constraints.

Test Plan (WIDTH=4):
- Divider round-trip: multiplicand=13, multiplier=5, addend=2 -> dout_valid exactly 5 cycles after the accepting edge's cycle, dout=67; dout holds 67 afterwards.
- Maximum operands: 255, 15, 255 -> dout=4080 (0xFF0); no overflow.
- Zero multiplier: 200, 0, 7 -> dout=7 after the same fixed latency. Also 0, 15, 0 -> dout=0 with a dout_valid pulse.
- Busy ignore: accept (3,3,0); pulse din_valid with (9,9,9) during CALC -> din_ready=0 throughout CALC, result 9, the second request is dropped.
- Back-to-back: keep din_valid=1 with (10,10,1) then (6,7,0) -> results 101 then 42, dout_valid pulses 5 cycles apart.
- Reset mid-operation: assert rst_n low 2 cycles after accepting (15,15,15) -> dout=0, dout_valid=0, din_ready=1 after release, no stray pulse; next op (2,3,1) -> 7.

Source files
------------

// File: rtl/shiftadd_multiplier_if.sv
// Operand/result bundle for the shift-add multiply-accumulate unit.
// The master issues operands; the slave (the multiplier) returns results.
interface shiftadd_multiplier_if #(
  parameter int WIDTH = 4
);
  logic [2*WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] addend;
  logic               din_valid;
  logic               din_ready;
  logic [3*WIDTH-1:0] dout;
  logic               dout_valid;

  modport master (
    output multiplicand, multiplier, addend, din_valid,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  multiplicand, multiplier, addend, din_valid,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/shiftadd_multiplier.sv
// Sequential shift-add multiply-accumulate: dout = multiplicand * multiplier + addend.
// Consumes one multiplier bit per cycle, so the latency is a fixed WIDTH cycles.
module shiftadd_multiplier #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  shiftadd_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0]    IDLE = 1'b0;
  localparam logic [0:0]    CALC = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]         state_reg;
  logic [3*WIDTH-1:0] acc_reg;
  logic [3*WIDTH-1:0] mcand_sh_reg;
  logic [WIDTH-1:0]   mplier_sh_reg;
  logic [CW-1:0]      cnt_reg;
  logic [3*WIDTH-1:0] dout_reg;
  logic               dout_valid_reg;
  logic [3*WIDTH-1:0] acc_next;

  // The result width absorbs the worst case product plus addend, so no carry out.
  assign acc_next = mplier_sh_reg[0] ? (acc_reg + mcand_sh_reg) : acc_reg;

  assign bus.din_ready  = (state_reg == IDLE);
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      mcand_sh_reg   <= '0;
      mplier_sh_reg  <= '0;
      cnt_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.din_valid) begin
            acc_reg       <= {{WIDTH{1'b0}}, bus.addend};
            mcand_sh_reg  <= {{WIDTH{1'b0}}, bus.multiplicand};
            mplier_sh_reg <= bus.multiplier;
            cnt_reg       <= '0;
            state_reg     <= CALC;
          end
        end
        default: begin
          acc_reg       <= acc_next;
          mcand_sh_reg  <= mcand_sh_reg << 1;
          mplier_sh_reg <= mplier_sh_reg >> 1;
          cnt_reg       <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            // Publish this iteration's sum directly rather than waiting a cycle for acc.
            dout_reg       <= acc_next;
            dout_valid_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
